// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: synchronizes NUM_CH oscillator inputs,
// selects one, and counts its rising edges over a gated window of clk cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; count/ovf hold the last result
// SETTLE | 2 cycles to flush the selected channel into the edge detector
// COUNT  | gate window open, rising edges increment the result counter
module ro_freq_counter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ro_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              cont,
  input  logic              start,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT} state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] ro_meta, ro_sync;
  logic [SEL_W-1:0]  ch_q;
  logic [WIN_W-1:0]  win_q, win_load;
  logic [WIN_W-1:0]  tmr, tmr_nxt;
  logic              sel_bit, sel_d, edge_det;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf_w, ovf_w_nxt;
  logic              capture, win_end;

  // Out-of-range channel numbers fall through to a constant 0.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == SEL_W'(i)) sel_bit = ro_sync[i];
    end
  end

  assign edge_det = sel_bit & ~sel_d;
  assign win_load = (win_q == '0) ? '0 : win_q - WIN_W'(1);
  assign busy     = (state != IDLE);

  always_comb begin
    cnt_nxt   = cnt;
    ovf_w_nxt = ovf_w;
    if (state == COUNT && edge_det) begin
      if (cnt == {CNT_W{1'b1}}) ovf_w_nxt = 1'b1;
      else                      cnt_nxt   = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    capture   = 1'b0;
    win_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = SETTLE;
          tmr_nxt   = WIN_W'(1);
        end
      end
      SETTLE: begin
        if (tmr == '0) begin
          state_nxt = COUNT;
          tmr_nxt   = win_load;
        end else begin
          tmr_nxt = tmr - WIN_W'(1);
        end
      end
      COUNT: begin
        if (tmr == '0) begin
          win_end = 1'b1;
          // Back-to-back windows reload the timer with no settle gap.
          if (cont) tmr_nxt = win_load;
          else      state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr - WIN_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmr     <= '0;
      ro_meta <= '0;
      ro_sync <= '0;
      sel_d   <= 1'b0;
      ch_q    <= '0;
      win_q   <= '0;
      cnt     <= '0;
      ovf_w   <= 1'b0;
      valid   <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      ro_meta <= ro_in;
      ro_sync <= ro_meta;
      sel_d   <= sel_bit;
      valid   <= win_end;
      if (capture) begin
        ch_q  <= ch_sel;
        win_q <= win_len;
      end
      if (win_end) begin
        count <= cnt_nxt;
        ovf   <= ovf_w_nxt;
        cnt   <= '0;
        ovf_w <= 1'b0;
      end else begin
        cnt   <= cnt_nxt;
        ovf_w <= ovf_w_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter: three instances (default, CNT_W=6,
// SEL_W=3) driven by directed start pulses; monitors check every valid pulse.
module tb_ro_freq_counter;

  typedef struct {
    int cnt;
    int ovf;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ro  = 4'd0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] ph = 8'd0;

  logic [1:0] ch_sel_a = '0;
  logic [2:0] ch_sel_c = '0;
  logic [1:0] ch_sel_b = '0;
  logic [7:0] win_len_a = '0, win_len_b = '0, win_len_c = '0;
  logic       cont_a = 1'b0, cont_b = 1'b0, cont_c = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic       busy_a, busy_b, busy_c;
  logic       valid_a, valid_b, valid_c;
  logic [7:0] count_a, count_c;
  logic [5:0] count_b;
  logic       ovf_a, ovf_b, ovf_c;

  exp_t q_a[$], q_b[$], q_c[$];

  ro_freq_counter #(.NUM_CH(4), .SEL_W(2), .CNT_W(8), .WIN_W(8)) dut_a (
    .clk(clk), .rst(rst), .ro_in(ro), .ch_sel(ch_sel_a), .win_len(win_len_a),
    .cont(cont_a), .start(start_a), .busy(busy_a), .valid(valid_a),
    .count(count_a), .ovf(ovf_a));

  ro_freq_counter #(.NUM_CH(4), .SEL_W(2), .CNT_W(6), .WIN_W(8)) dut_b (
    .clk(clk), .rst(rst), .ro_in(ro), .ch_sel(ch_sel_b), .win_len(win_len_b),
    .cont(cont_b), .start(start_b), .busy(busy_b), .valid(valid_b),
    .count(count_b), .ovf(ovf_b));

  ro_freq_counter #(.NUM_CH(4), .SEL_W(3), .CNT_W(8), .WIN_W(8)) dut_c (
    .clk(clk), .rst(rst), .ro_in(ro), .ch_sel(ch_sel_c), .win_len(win_len_c),
    .cont(cont_c), .start(start_c), .busy(busy_c), .valid(valid_c),
    .count(count_c), .ovf(ovf_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ro[0],ro[1]: period 2; ro[2]: period 4; ro[3]: period 8 (in clk cycles)
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ph = ph + 8'd1;
      ro = {ph[2], ph[1], ph[0], ph[0]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int n);
    go_to(n);
    @(negedge clk);
  endtask

  task automatic kick(input int inst, input int ch, input int win,
                      input int ec, input int eo, input bit push);
    exp_t e;
    int   w;
    w     = (win == 0) ? 1 : win;
    e.cnt = ec;
    e.ovf = eo;
    e.cyc = cyc + 3 + w;
    case (inst)
      0: begin ch_sel_a = 2'(ch); win_len_a = 8'(win); start_a = 1'b1; if (push) q_a.push_back(e); end
      1: begin ch_sel_b = 2'(ch); win_len_b = 8'(win); start_b = 1'b1; if (push) q_b.push_back(e); end
      default: begin ch_sel_c = 3'(ch); win_len_c = 8'(win); start_c = 1'b1; if (push) q_c.push_back(e); end
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_a) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        check("a_count", 32'(count_a), e.cnt);
        check("a_ovf", 32'(ovf_a), e.ovf);
        check("a_valid_cycle", cyc, e.cyc);
      end
    end
    if (valid_b) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        check("b_count", 32'(count_b), e.cnt);
        check("b_ovf", 32'(ovf_b), e.ovf);
        check("b_valid_cycle", cyc, e.cyc);
      end
    end
    if (valid_c) begin
      if (q_c.size() == 0) check("c_unexpected_valid", 1, 0);
      else begin
        e = q_c.pop_front();
        check("c_count", 32'(count_c), e.cnt);
        check("c_ovf", 32'(ovf_c), e.ovf);
        check("c_valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int   c;
    exp_t e;

    sample_at(3);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_count", 32'(count_a), 0);
    check("rst_ovf", 32'(ovf_b), 0);
    go_to(4);
    rst = 1'b0;

    // Single window, ch2 period 4, W=40; inputs and a start disturbed mid-run
    go_to(10);
    c = cyc;
    kick(0, 2, 40, 10, 0, 1'b1);
    ch_sel_a  = 2'd0;
    win_len_a = 8'd3;
    sample_at(c + 1);
    check("a_busy_settle", 32'(busy_a), 1);
    go_to(c + 10);
    start_a = 1'b1;
    go_to(c + 11);
    start_a = 1'b0;
    sample_at(c + 42);
    check("a_busy_last", 32'(busy_a), 1);
    check("a_count_held", 32'(count_a), 0);
    sample_at(c + 43);
    check("a_busy_done", 32'(busy_a), 0);
    sample_at(c + 50);
    check("a_count_hold", 32'(count_a), 10);

    // Continuous: three windows, cont dropped during the third
    go_to(c + 60);
    c = cyc;
    cont_a = 1'b1;
    kick(0, 2, 40, 10, 0, 1'b1);
    e.cnt = 10; e.ovf = 0;
    e.cyc = c + 83;  q_a.push_back(e);
    e.cyc = c + 123; q_a.push_back(e);
    sample_at(c + 83);
    check("a_cont_busy", 32'(busy_a), 1);
    go_to(c + 100);
    cont_a = 1'b0;
    sample_at(c + 123);
    check("a_cont_idle", 32'(busy_a), 0);
    sample_at(c + 130);
    check("a_cont_stay_idle", 32'(busy_a), 0);

    // Other rates on instance A
    kick(0, 3, 40, 5, 0, 1'b1);
    go_to(cyc + 50);
    kick(0, 0, 16, 8, 0, 1'b1);
    go_to(cyc + 25);

    // CNT_W=6 saturation then a clean run
    c = cyc;
    kick(1, 1, 255, 63, 1, 1'b1);
    sample_at(c + 262);
    check("b_ovf_hold", 32'(ovf_b), 1);
    kick(1, 1, 20, 10, 0, 1'b1);
    go_to(cyc + 30);

    // Out-of-range channel and zero-length window
    kick(2, 5, 10, 0, 0, 1'b1);
    go_to(cyc + 15);
    kick(2, 5, 0, 0, 0, 1'b1);
    go_to(cyc + 8);

    // Reset mid-COUNT aborts with no valid
    c = cyc;
    kick(0, 2, 40, 0, 0, 1'b0);
    go_to(c + 20);
    rst = 1'b1;
    sample_at(c + 21);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_count", 32'(count_a), 0);
    go_to(c + 22);
    // Reset beats a coincident start
    start_a = 1'b1;
    go_to(c + 23);
    rst = 1'b0;
    start_a = 1'b0;
    sample_at(c + 24);
    check("rst_start_busy", 32'(busy_a), 0);
    go_to(c + 70);

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    check("c_queue_empty", q_c.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
